frame_burst_controller: RTL and testbench

//  Sequences frame_generator to send a programmed burst of frames, with a configurable inter-frame gap (IPG).

---
 rtl/frame_burst_controller.sv | 197 +++++++++++++++++++
 tb/tb_frame_burst_controller.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_burst_controller.sv
// Purpose: sequences a frame generator through a programmed burst of frames with an inter-frame gap.
// Latency: o_start rises 1 cycle after the i_enable rising edge; the next o_start rises ipg+1 cycles after the EOF beat.
// Backpressure: none; waits on the generator's SOF/EOF beats and aborts with a sticky error after TIMEOUT_CYCLES.
module frame_burst_controller #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic [15:0]           i_num_frames,
    input  logic [7:0]            i_ipg_cycles,
    input  logic                  i_inject_en,
    input  logic [15:0]           i_inject_frame,
    input  logic [7:0]            i_inject_code,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic [CTRL_WIDTH-1:0] i_tx_ctrl,
    output logic                  o_start,
    output logic [7:0]            o_interrupt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [15:0]           o_frame_count,
    output logic                  o_timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_SOF,
        S_WAIT_EOF,
        S_GAP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          enable_q;
    logic [15:0]   num_q;
    logic [7:0]    ipg_q;
    logic          inj_en_q;
    logic [15:0]   inj_frame_q;
    logic [7:0]    inj_code_q;
    logic [7:0]    gap_cnt;
    logic [TW-1:0] to_cnt;

    logic          sof_beat;
    logic          eof_beat;
    logic          enable_rise;
    logic [15:0]   count_inc;
    logic          inj_match;
    logic          to_hit;
    logic          stop_now;
    logic          stop_gap;
    logic          burst_go;
    logic          frame_done;
    logic [7:0]    int_n;

    // Frame boundary detection: SOF only in lane 0, EOF in any control lane.
    always_comb begin
        sof_beat = i_tx_ctrl[0] && (i_tx_data[7:0] == 8'hFB);
        eof_beat = 1'b0;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (i_tx_ctrl[i] && (i_tx_data[8*i +: 8] == 8'hFD)) begin
                eof_beat = 1'b1;
            end
        end
    end

    // Shared helper terms: edge detect, saturating count, injection match, timeout and stop decisions.
    always_comb begin
        enable_rise = i_enable && !enable_q;
        count_inc   = (o_frame_count == 16'hFFFF) ? o_frame_count : o_frame_count + 16'd1;
        inj_match   = inj_en_q && (o_frame_count == inj_frame_q);
        to_hit      = (to_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                      (((state == S_WAIT_SOF) && !sof_beat) ||
                       ((state == S_WAIT_EOF) && !eof_beat));
        // With no gap the burst-end decision is taken on the EOF beat itself, using the count it produces.
        stop_now    = ((num_q != 16'd0) && (count_inc == num_q)) || !i_enable;
        stop_gap    = ((num_q != 16'd0) && (o_frame_count == num_q)) || !i_enable;
    end

    // Next-state logic and Moore outputs.
    always_comb begin
        state_n    = state;
        burst_go   = 1'b0;
        frame_done = 1'b0;
        o_start    = (state == S_START) || (state == S_WAIT_SOF);
        o_busy     = (state != S_IDLE) && (state != S_DONE);
        case (state)
            S_IDLE, S_DONE: begin
                if (enable_rise) begin
                    burst_go = 1'b1;
                    state_n  = S_START;
                end
            end
            S_START: begin
                state_n = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (sof_beat && eof_beat) begin
                    frame_done = 1'b1;
                    if (ipg_q != 8'd0) state_n = S_GAP;
                    else               state_n = stop_now ? S_DONE : S_START;
                end else if (sof_beat) begin
                    state_n = S_WAIT_EOF;
                end else if (to_hit) begin
                    state_n = S_DONE;
                end
            end
            S_WAIT_EOF: begin
                if (eof_beat) begin
                    frame_done = 1'b1;
                    if (ipg_q != 8'd0) state_n = S_GAP;
                    else               state_n = stop_now ? S_DONE : S_START;
                end else if (to_hit) begin
                    state_n = S_DONE;
                end
            end
            S_GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_n = stop_gap ? S_DONE : S_START;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Injection code is registered so it appears from the cycle after SOF through the cycle after EOF.
    always_comb begin
        int_n = 8'h00;
        if (!to_hit) begin
            if (((state == S_WAIT_SOF) && sof_beat && inj_match) ||
                ((state == S_WAIT_EOF) && inj_match)) begin
                int_n = inj_code_q;
            end
        end
    end

    // State register, burst configuration latch and status outputs.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state         <= S_IDLE;
            enable_q      <= 1'b0;
            num_q         <= 16'd0;
            ipg_q         <= 8'd0;
            inj_en_q      <= 1'b0;
            inj_frame_q   <= 16'd0;
            inj_code_q    <= 8'd0;
            o_frame_count <= 16'd0;
            o_timeout_err <= 1'b0;
            o_done        <= 1'b0;
            o_interrupt   <= 8'h00;
        end else begin
            state       <= state_n;
            enable_q    <= i_enable;
            o_done      <= (state_n == S_DONE) && (state != S_DONE);
            o_interrupt <= int_n;
            if (burst_go) begin
                num_q         <= i_num_frames;
                ipg_q         <= i_ipg_cycles;
                inj_en_q      <= i_inject_en;
                inj_frame_q   <= i_inject_frame;
                inj_code_q    <= i_inject_code;
                o_frame_count <= 16'd0;
                o_timeout_err <= 1'b0;
            end else begin
                if (frame_done) o_frame_count <= count_inc;
                if (to_hit)     o_timeout_err <= 1'b1;
            end
        end
    end

    // Gap and timeout counters; the timeout spans both wait states of one frame and clears elsewhere.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            gap_cnt <= 8'd0;
            to_cnt  <= '0;
        end else begin
            if (frame_done && (ipg_q != 8'd0)) begin
                gap_cnt <= ipg_q - 8'd1;
            end else if ((state == S_GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
            if ((state == S_WAIT_SOF) || (state == S_WAIT_EOF)) begin
                to_cnt <= to_cnt + TW'(1);
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_frame_burst_controller.sv
// Purpose: directed bench for frame_burst_controller with a small frame generator model and event logs.
// Latency: checks start latency, EOF-to-start spacing, injection window and timeout duration by cycle stamps.
// Backpressure: generator answers o_start one cycle later; every wait is bounded by a cycle budget.
module tb_frame_burst_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] num_frames;
    logic [7:0]  ipg_cycles;
    logic        inject_en;
    logic [15:0] inject_frame;
    logic [7:0]  inject_code;
    logic [63:0] tx_data;
    logic [7:0]  tx_ctrl;
    logic        start;
    logic [7:0]  interrupt;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic        timeout_err;

    frame_burst_controller dut (
        .clk            (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_num_frames   (num_frames),
        .i_ipg_cycles   (ipg_cycles),
        .i_inject_en    (inject_en),
        .i_inject_frame (inject_frame),
        .i_inject_code  (inject_code),
        .i_tx_data      (tx_data),
        .i_tx_ctrl      (tx_ctrl),
        .o_start        (start),
        .o_interrupt    (interrupt),
        .o_busy         (busy),
        .o_done         (done),
        .o_frame_count  (frame_count),
        .o_timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int gen_mode = 0;   // 0 silent, 1 ten-beat frame, 2 single SOF+EOF beat
    int en_cyc   = 0;

    int rise_q[$];
    int sof_q[$];
    int eof_q[$];
    int start_hi = 0;
    int done_cnt = 0;
    int nz_cnt   = 0;
    int nz_first = -1;
    int nz_last  = -1;
    int nz_bad   = 0;
    logic [7:0] exp_code = 8'h00;
    logic start_d = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1000;
    endfunction

    function automatic logic is_sof(input logic [63:0] d, input logic [7:0] c);
        return c[0] && (d[7:0] == 8'hFB);
    endfunction

    function automatic logic is_eof(input logic [63:0] d, input logic [7:0] c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (c[i] && (d[8*i +: 8] == 8'hFD)) r = 1'b1;
        end
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        rise_q.delete();
        sof_q.delete();
        eof_q.delete();
        start_hi = 0;
        done_cnt = 0;
        nz_cnt   = 0;
        nz_first = -1;
        nz_last  = -1;
        nz_bad   = 0;
    endtask

    task automatic start_burst(input logic [15:0] n, input logic [7:0] ipg,
                               input logic ie, input logic [15:0] ifr, input logic [7:0] code);
        num_frames   = n;
        ipg_cycles   = ipg;
        inject_en    = ie;
        inject_frame = ifr;
        inject_code  = code;
        exp_code     = code;
        enable       = 1'b1;
        en_cyc       = cyc;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick(1);
            n++;
        end
        chk(tag, (done_cnt != 0), 1);
    endtask

    task automatic wait_sofs(input int k, input int limit, input string tag);
        int n;
        n = 0;
        while (sof_q.size() < k && n < limit) begin
            tick(1);
            n++;
        end
        chk(tag, (sof_q.size() >= k), 1);
    endtask

    // cycle stamp
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // generator model: answers o_start seen in the previous cycle, one idle cycle after each frame
    initial begin
        int   pos;
        logic prev;
        pos     = -1;
        prev    = 1'b0;
        tx_data = 64'h0707070707070707;
        tx_ctrl = 8'hFF;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                pos     = -1;
                prev    = 1'b0;
                tx_data = 64'h0707070707070707;
                tx_ctrl = 8'hFF;
            end else begin
                if (pos == -1 && prev && gen_mode != 0) pos = 0;
                if (pos < 0) begin
                    tx_data = 64'h0707070707070707;
                    tx_ctrl = 8'hFF;
                    pos     = -1;
                end else if (gen_mode == 2) begin
                    tx_data = 64'h070707070707FDFB;
                    tx_ctrl = 8'hFF;
                    pos     = -2;
                end else if (pos == 0) begin
                    tx_data = 64'hD5555555555555FB;
                    tx_ctrl = 8'h01;
                    pos++;
                end else if (pos < 9) begin
                    tx_data = 64'h112233445_5FD6600 + 64'(pos);
                    tx_ctrl = 8'h00;
                    pos++;
                end else begin
                    tx_data = 64'h07070707FD112233;
                    tx_ctrl = 8'hF8;
                    pos     = -2;
                end
                prev = start;
            end
        end
    end

    // monitor: event logs sampled mid-cycle
    initial forever begin
        @(negedge clk);
        if (start && !start_d) rise_q.push_back(cyc);
        start_d = start;
        if (start) start_hi++;
        if (done) done_cnt++;
        if (is_sof(tx_data, tx_ctrl)) sof_q.push_back(cyc);
        if (is_eof(tx_data, tx_ctrl)) eof_q.push_back(cyc);
        if (interrupt != 8'h00) begin
            if (nz_cnt == 0) nz_first = cyc;
            nz_last = cyc;
            nz_cnt++;
            if (interrupt != exp_code) nz_bad++;
        end
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        num_frames   = 16'd0;
        ipg_cycles   = 8'd0;
        inject_en    = 1'b0;
        inject_frame = 16'd0;
        inject_code  = 8'd0;
        tick(3);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_int", interrupt, 0);
        rst = 1'b0;
        tick(2);

        // 1: three frames, ipg 4
        clear_log();
        gen_mode = 1;
        start_burst(16'd3, 8'd4, 1'b0, 16'd0, 8'h00);
        wait_done(200, "t1_done_seen");
        tick(3);
        chk("t1_rises", rise_q.size(), 3);
        chk("t1_start_lat", qat(rise_q, 0) - en_cyc, 1);
        chk("t1_gap0", qat(rise_q, 1) - qat(eof_q, 0), 5);
        chk("t1_gap1", qat(rise_q, 2) - qat(eof_q, 1), 5);
        chk("t1_count", frame_count, 3);
        chk("t1_eofs", eof_q.size(), 3);
        chk("t1_done_once", done_cnt, 1);
        chk("t1_busy", busy, 0);
        enable = 1'b0;
        tick(2);

        // 2: continuous, enable dropped during frame 2
        clear_log();
        start_burst(16'd0, 8'd2, 1'b0, 16'd0, 8'h00);
        wait_sofs(3, 300, "t2_sof3");
        tick(3);
        enable = 1'b0;
        wait_done(100, "t2_done_seen");
        tick(3);
        chk("t2_count", frame_count, 3);
        chk("t2_eofs", eof_q.size(), 3);
        chk("t2_rises", rise_q.size(), 3);
        tick(2);

        // 3: injection on frame 1
        clear_log();
        start_burst(16'd3, 8'd3, 1'b1, 16'd1, 8'h02);
        wait_done(200, "t3_done_seen");
        chk("t3_first", nz_first, qat(sof_q, 1) + 1);
        chk("t3_last", nz_last, qat(eof_q, 1) + 1);
        chk("t3_len", nz_cnt, 10);
        chk("t3_val", nz_bad, 0);
        chk("t3_count", frame_count, 3);
        enable = 1'b0;
        tick(2);

        // 4: silent generator times out, next burst clears the error
        clear_log();
        gen_mode = 0;
        start_burst(16'd1, 8'd0, 1'b0, 16'd0, 8'h00);
        wait_done(5000, "t4_done_seen");
        chk("t4_err", timeout_err, 1);
        chk("t4_count", frame_count, 0);
        chk("t4_start_cycles", start_hi, 4097);
        chk("t4_done_once", done_cnt, 1);
        chk("t4_start_low", start, 0);
        chk("t4_busy", busy, 0);
        enable = 1'b0;
        tick(2);
        clear_log();
        gen_mode = 1;
        start_burst(16'd1, 8'd0, 1'b0, 16'd0, 8'h00);
        tick(1);
        chk("t4_err_clr", timeout_err, 0);
        wait_done(100, "t4b_done_seen");
        chk("t4b_count", frame_count, 1);
        chk("t4b_err", timeout_err, 0);
        enable = 1'b0;
        tick(2);

        // 5: SOF and EOF in one beat, no gap
        clear_log();
        gen_mode = 2;
        start_burst(16'd2, 8'd0, 1'b0, 16'd0, 8'h00);
        wait_done(100, "t5_done_seen");
        chk("t5_count", frame_count, 2);
        chk("t5_eofs", eof_q.size(), 2);
        chk("t5_eof_spacing", qat(eof_q, 1) - qat(eof_q, 0), 2);
        chk("t5_start_cycles", start_hi, 4);
        enable = 1'b0;
        tick(2);

        // 6: reset in WAIT_EOF of frame 1, then a clean restart
        clear_log();
        gen_mode = 1;
        start_burst(16'd3, 8'd2, 1'b1, 16'd1, 8'h5A);
        wait_sofs(2, 200, "t6_sof2");
        tick(3);
        chk("t6_pre_count", frame_count, 1);
        chk("t6_pre_int", interrupt, 8'h5A);
        chk("t6_pre_busy", busy, 1);
        rst    = 1'b1;
        enable = 1'b0;
        tick(1);
        chk("t6_rst_start", start, 0);
        chk("t6_rst_int", interrupt, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", frame_count, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_err", timeout_err, 0);
        rst = 1'b0;
        tick(2);
        clear_log();
        start_burst(16'd3, 8'd2, 1'b0, 16'd0, 8'h00);
        wait_done(300, "t6_done_seen");
        chk("t6_count", frame_count, 3);
        chk("t6_rises", rise_q.size(), 3);
        chk("t6_err", timeout_err, 0);
        enable = 1'b0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
